// File: rtl/blink_code_pkg.sv
// Shared types and helpers for the blink_code LED status signaller.
package blink_code_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2,
        StGap  = 2'd3
    } state_e;

    // Counter must hold the largest per-state terminal value (TICKS-1).
    function automatic int unsigned tick_cnt_w(int unsigned on_t, int unsigned off_t,
                                               int unsigned gap_t);
        int unsigned m;
        m = on_t;
        if (off_t > m) m = off_t;
        if (gap_t > m) m = gap_t;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/blink_code_if.sv
// Request/status bundle between the control logic and the blink_code player.
interface blink_code_if #(
    parameter int unsigned CODE_W = 4
);
    logic              tick;
    logic              start;
    logic [CODE_W-1:0] code;
    logic              led;
    logic              busy;
    logic              done;

    modport master (
        output tick, start, code,
        input  led, busy, done
    );

    modport slave (
        input  tick, start, code,
        output led, busy, done
    );
endinterface

// File: rtl/blink_tick_cnt.sv
// Counts tick pulses within one FSM state; flags the tick that reaches the terminal value.
module blink_tick_cnt #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] term,
    output logic         reached
);

    logic [W-1:0] cnt_q;

    assign reached = tick && (cnt_q == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/blink_code.sv
// Plays a code as N LED blinks followed by a gap, timed by upstream tick pulses.
// Define BLINK_CODE_REPEAT_EN to re-sample code at each gap end and replay back-to-back.
module blink_code
    import blink_code_pkg::*;
#(
    parameter int unsigned CODE_W    = 4,
    parameter int unsigned ON_TICKS  = 1,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned GAP_TICKS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    blink_code_if.slave  bus
);

    localparam int unsigned CW = tick_cnt_w(ON_TICKS, OFF_TICKS, GAP_TICKS);
    localparam logic [CW-1:0] ON_TERM  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_TERM = CW'(OFF_TICKS - 1);
    localparam logic [CW-1:0] GAP_TERM = CW'(GAP_TICKS - 1);

    state_e            state_q;
    logic [CODE_W-1:0] remaining_q;
    logic              led_q;
    logic              busy_q;
    logic              done_q;

    logic [CW-1:0]     term;
    logic              reached;
    logic              cnt_clear;

    always_comb begin
        term = ON_TERM;
        case (state_q)
            StOff:   term = OFF_TERM;
            StGap:   term = GAP_TERM;
            default: term = ON_TERM;
        endcase
    end

    // Holding the counter clear in idle means a tick coinciding with start is not counted.
    assign cnt_clear = (state_q == StIdle) || reached;

    blink_tick_cnt #(
        .W (CW)
    ) u_tick_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .tick    (bus.tick),
        .term    (term),
        .reached (reached)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            led_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.code != '0) begin
                            remaining_q <= bus.code;
                            state_q     <= StOn;
                            led_q       <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StOn: begin
                    if (reached) begin
                        remaining_q <= remaining_q - CODE_W'(1);
                        led_q       <= 1'b0;
                        state_q     <= (remaining_q == CODE_W'(1)) ? StGap : StOff;
                    end
                end
                StOff: begin
                    if (reached) begin
                        led_q   <= 1'b1;
                        state_q <= StOn;
                    end
                end
                StGap: begin
                    if (reached) begin
                        done_q <= 1'b1;
`ifdef BLINK_CODE_REPEAT_EN
                        if (bus.code != '0) begin
                            remaining_q <= bus.code;
                            led_q       <= 1'b1;
                            state_q     <= StOn;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.led  = led_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_blink_code.sv
// Self-checking bench for blink_code: vector table, hand sequences and a random run vs a model.
module tb_blink_code;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blink_code_if #(.CODE_W(CW)) bus_a ();
    blink_code_if #(.CODE_W(CW)) bus_b ();

    blink_code #(
        .CODE_W (CW)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    blink_code #(
        .CODE_W    (CW),
        .ON_TICKS  (2),
        .OFF_TICKS (3),
        .GAP_TICKS (4)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       start;
        bit [3:0] code;
        bit       tick;
        bit [2:0] exp;   // {led, busy, done}
    } vec_t;

    // Reference model: progress is the count of ticks since acceptance; the LED pattern
    // follows from dividing that count by the blink period.
    bit m_act[2];
    int m_n[2];
    int m_e[2];
    bit m_done[2];

    function automatic int on_t(int i);  return (i == 0) ? 1 : 2; endfunction
    function automatic int off_t(int i); return (i == 0) ? 1 : 3; endfunction
    function automatic int gap_t(int i); return 4; endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_n[i] = 0; m_e[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic model_step(int i, bit st, int cd, bit tk);
        int len;
        len = m_n[i] * on_t(i) + (m_n[i] - 1) * off_t(i) + gap_t(i);
        m_done[i] = 0;
        if (!m_act[i]) begin
            if (st) begin
                if (cd == 0) m_done[i] = 1;
                else begin m_act[i] = 1; m_n[i] = cd; m_e[i] = 0; end
            end
        end else if (tk) begin
            m_e[i]++;
            if (m_e[i] == len) begin
                m_act[i] = 0;
                m_done[i] = 1;
`ifdef BLINK_CODE_REPEAT_EN
                if (cd != 0) begin m_act[i] = 1; m_n[i] = cd; m_e[i] = 0; end
`endif
            end
        end
    endtask

    function automatic bit [2:0] model_out(int i);
        int p;
        bit led;
        p = on_t(i) + off_t(i);
        led = m_act[i] && (m_e[i] / p < m_n[i]) && (m_e[i] % p < on_t(i));
        return {led, m_act[i], m_done[i]};
    endfunction

    function automatic bit [2:0] out_a();
        return {bus_a.led, bus_a.busy, bus_a.done};
    endfunction

    function automatic bit [2:0] out_b();
        return {bus_b.led, bus_b.busy, bus_b.done};
    endfunction

    task automatic check(string name, int idx, bit [2:0] act, bit [2:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: led/busy/done got %b want %b", name, idx, act, exp);
        end
    endtask

    task automatic drive(bit st, bit [3:0] cd, bit tk);
        bus_a.start = st; bus_a.code = cd; bus_a.tick = tk;
        bus_b.start = st; bus_b.code = cd; bus_b.tick = tk;
        model_step(0, st, int'(cd), tk);
        model_step(1, st, int'(cd), tk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 4'd0, 0);
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    vec_t vecs[15];

    initial begin
        bit [2:0] e;
        int den;
        bit st;
        bit [3:0] cd;

        vecs[0]  = '{1, 4'd3, 1, 3'b000};
        vecs[1]  = '{0, 4'd0, 1, 3'b110};
        vecs[2]  = '{0, 4'd0, 1, 3'b010};
        vecs[3]  = '{1, 4'd7, 1, 3'b110};   // start while busy must be ignored
        vecs[4]  = '{0, 4'd0, 1, 3'b010};
        vecs[5]  = '{0, 4'd0, 1, 3'b110};
        vecs[6]  = '{0, 4'd0, 1, 3'b010};
        vecs[7]  = '{0, 4'd0, 1, 3'b010};
        vecs[8]  = '{0, 4'd0, 1, 3'b010};
        vecs[9]  = '{0, 4'd0, 1, 3'b010};
        vecs[10] = '{0, 4'd0, 1, 3'b001};
        vecs[11] = '{0, 4'd0, 1, 3'b000};
        vecs[12] = '{1, 4'd0, 1, 3'b000};   // code 0: done only
        vecs[13] = '{0, 4'd0, 1, 3'b001};
        vecs[14] = '{0, 4'd0, 0, 3'b000};

        drive(0, 4'd0, 0);
        model_reset();
        #1;
        check("reset_a", 0, out_a(), 3'b000);
        check("reset_b", 0, out_b(), 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            check("table", i, out_a(), vecs[i].exp);
            drive(vecs[i].start, vecs[i].code, vecs[i].tick);
            @(negedge clk);
        end

        // Asynchronous reset during an ON phase.
        do_reset();
        drive(1, 4'd3, 0);
        @(negedge clk);
        check("pre_rst_on", 0, out_a(), 3'b110);
        drive(0, 4'd0, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_a", 0, out_a(), 3'b000);
        check("async_rst_b", 0, out_b(), 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(0, 4'd0, 1);
            @(negedge clk);
            check("post_rst_idle", c, out_a(), 3'b000);
        end

        // ON_TICKS=2, tick every 4th cycle, code 1; tick at the start cycle is not counted.
        do_reset();
        for (int c = 0; c < 28; c++) begin
            e = {(c >= 1 && c <= 8), (c >= 1 && c <= 24), (c == 25)};
            check("slow_tick_b", c, out_b(), e);
            drive(c == 0, (c == 0) ? 4'd1 : 4'd0, (c % 4) == 0);
            @(negedge clk);
        end

`ifdef BLINK_CODE_REPEAT_EN
        do_reset();
        for (int c = 0; c < 26; c++) begin
            e[2] = (c >= 1 && c <= 21) && (((c - 1) % 7 == 0) || ((c - 1) % 7 == 2));
            e[1] = (c >= 1 && c <= 21);
            e[0] = (c == 8) || (c == 15) || (c == 22);
            check("repeat_a", c, out_a(), e);
            drive(c == 0, (c < 16) ? 4'd2 : 4'd0, 1);
            @(negedge clk);
        end
`endif

        // Random run against the model, varying tick density per block.
        do_reset();
        for (int blk = 0; blk < 4; blk++) begin
            case (blk)
                0:       den = 1;
                1:       den = 2;
                2:       den = 3;
                default: den = 5;
            endcase
            for (int n = 0; n < 200; n++) begin
                st = ($urandom % 6) == 0;
                cd = 4'($urandom % 16);
                if (($urandom % 4) == 0) cd = 4'd0;
                drive(st, cd, ($urandom % den) == 0);
                @(negedge clk);
                check("rand_a", blk * 200 + n, out_a(), model_out(0));
                check("rand_b", blk * 200 + n, out_b(), model_out(1));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
